// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and constants for the data-memory bridge.
// Holds the FSM encoding, RISC-V load/store funct3 codes and timeout default.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int TIMEOUT_DEF = 255;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half of a bus word
// and sign- or zero-extends it according to funct3.
module load_align
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'd0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'd0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: core load/store port onto a req/gnt/rvalid data bus.
// Checks alignment, replicates store lanes, aligns loads, times out stalls.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [3:0]  I_wmask,
  input  logic [2:0]  I_funct3,
  input  logic        I_rd,
  input  logic        I_we,
  output logic [31:0] O_rdata,
  output logic        O_rdata_valid,
  output logic        O_stall,
  output logic        O_err,
  output logic        O_bus_req,
  output logic        O_bus_we,
  output logic [31:0] O_bus_addr,
  output logic [31:0] O_bus_wdata,
  output logic [3:0]  O_bus_wstrb,
  input  logic        I_bus_gnt,
  input  logic        I_bus_rvalid,
  input  logic [31:0] I_bus_rdata,
  input  logic        I_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic [2:0]    f3;
  logic          is_half;
  logic          is_word;
  logic          bad;
  logic          tmo;
  logic [31:0]   wrep;
  logic [31:0]   aligned;

  always_comb begin
    is_half = I_funct3[1:0] == 2'b01;
    is_word = I_funct3[1:0] == 2'b10;
    bad = (I_rd & I_we)
        | (is_half & I_addr[0])
        | (is_word & (|I_addr[1:0]))
        | (I_rd & ~I_we & ~load_f3_ok(I_funct3));
    tmo = cnt == CW'(TIMEOUT - 1);
  end

  always_comb begin
    unique case (1'b1)
      (I_funct3[1:0] == 2'b00): wrep = {4{I_wdata[7:0]}};
      is_half:                  wrep = {2{I_wdata[15:0]}};
      default:                  wrep = I_wdata;
    endcase
  end

  load_align u_align (
    .word   (I_bus_rdata),
    .lane   (lane),
    .funct3 (f3),
    .data   (aligned)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (I_rd | I_we) state_nx = bad ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (I_bus_gnt) state_nx = O_bus_we ? S_DONE : S_RESP;
        else if (tmo)  state_nx = S_DONE;
      end
      S_RESP: begin
        if (I_bus_rvalid | tmo) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    O_bus_req = state == S_REQ;
    O_stall   = ((state == S_IDLE) & (I_rd | I_we))
              | (state == S_REQ) | (state == S_RESP);
  end

  // Pulses last one cycle: they are set only on the edge entering DONE.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt           <= '0;
      lane          <= '0;
      f3            <= '0;
      O_rdata       <= '0;
      O_rdata_valid <= 1'b0;
      O_err         <= 1'b0;
      O_bus_we      <= 1'b0;
      O_bus_addr    <= '0;
      O_bus_wdata   <= '0;
      O_bus_wstrb   <= '0;
    end else begin
      O_rdata_valid <= 1'b0;
      O_err         <= 1'b0;
      if ((state == S_REQ || state == S_RESP) && state_nx == state)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      case (state)
        S_IDLE: begin
          if ((I_rd | I_we) & ~bad) begin
            O_bus_addr  <= {I_addr[31:2], 2'b00};
            O_bus_wdata <= wrep;
            O_bus_wstrb <= I_wmask;
            O_bus_we    <= I_we;
            lane        <= I_addr[1:0];
            f3          <= I_funct3;
          end else if (I_rd | I_we) begin
            O_err <= 1'b1;
          end
        end
        S_REQ: begin
          if (I_bus_gnt) O_err <= O_bus_we & I_bus_err;
          else if (tmo)  O_err <= 1'b1;
        end
        S_RESP: begin
          if (I_bus_rvalid) begin
            if (I_bus_err) begin
              O_err <= 1'b1;
            end else begin
              O_rdata       <= aligned;
              O_rdata_valid <= 1'b1;
            end
          end else if (tmo) begin
            O_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
